// File: rtl/pdm_mic_array_frontend.sv
// PDM microphone-array capture front-end: shared PDM clock, per-line synchronisers,
// L/R phase sampling and warm-up/run sequencing ahead of the per-channel CIC stage.
module pdm_mic_array_frontend #(
  parameter int unsigned N_LINES = 10,
  parameter int unsigned DDR     = 1,
  parameter int unsigned DIV     = 8,
  parameter int unsigned SMP_L   = DIV / 2 - 1,
  parameter int unsigned SMP_R   = DIV - 1,
  parameter int unsigned SYNC    = 2,
  parameter int unsigned WARMUP  = 4096,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned N_CH   = N_LINES * (DDR + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  output logic               pdm_clk_o,
  input  logic [N_LINES-1:0] pdm_data_i,
  output logic [N_CH-1:0]    bits_o,
  output logic               bits_valid_o,
  output logic [1:0]         state_o,
  output logic [CNT_W-1:0]   frame_cnt_o
);

  localparam int unsigned DIV_W  = $clog2(DIV);
  localparam int unsigned WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  localparam logic [DIV_W-1:0]  DivLast  = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0]  DivHalf  = DIV_W'(DIV / 2);
  localparam logic [DIV_W-1:0]  SmpLPos  = DIV_W'(SMP_L);
  localparam logic [DIV_W-1:0]  SmpRPos  = DIV_W'(SMP_R);
  localparam logic [WARM_W-1:0] WarmLast = WARM_W'(WARMUP - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWarmup = 2'd1,
    StRun    = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [DIV_W-1:0]              div_q, div_d;
  logic [WARM_W-1:0]             warm_q, warm_d;
  logic [CNT_W-1:0]              frame_q, frame_d;
  logic [N_CH-1:0]               bits_q, bits_d;
  logic                          valid_q, valid_d;
  logic                          pdm_clk_q, pdm_clk_d;
  logic [SYNC-1:0][N_LINES-1:0]  sync_q, sync_d;
  logic [N_LINES-1:0]            l_q, l_d, r_q, r_d;
  logic [N_CH-1:0]               frame_bits;
  logic                          active, wrap;

  // Channel 2k is the L mic of line k, 2k+1 the R mic.
  if (DDR != 0) begin : g_ddr
    for (genvar k = 0; k < N_LINES; k++) begin : g_line
      assign frame_bits[2*k]   = l_q[k];
      assign frame_bits[2*k+1] = r_q[k];
    end
  end else begin : g_sdr
    assign frame_bits = r_q;
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    warm_d    = warm_q;
    frame_d   = frame_q;
    bits_d    = bits_q;
    valid_d   = 1'b0;
    pdm_clk_d = 1'b0;
    l_d       = l_q;
    r_d       = r_q;
    sync_d    = {sync_q[SYNC-2:0], pdm_data_i};

    active = (state_q != StIdle);
    wrap   = active && (div_q == DivLast);

    if (div_q == SmpLPos) l_d = sync_q[SYNC-1];
    if (div_q == SmpRPos) r_d = sync_q[SYNC-1];

    if (active) begin
      div_d     = wrap ? '0 : div_q + 1'b1;
      pdm_clk_d = (div_q < DivHalf);
    end

    // EN is only acted on at a period wrap so the PDM clock never sees a runt pulse.
    unique case (state_q)
      StIdle: begin
        if (EN) begin
          state_d = StWarmup;
          warm_d  = '0;
          frame_d = '0;
        end
      end
      StWarmup: begin
        if (wrap) begin
          if (!EN) begin
            state_d = StIdle;
          end else if (warm_q == WarmLast) begin
            state_d = StRun;
          end else begin
            warm_d = warm_q + 1'b1;
          end
        end
      end
      StRun: begin
        if (wrap) begin
          bits_d  = frame_bits;
          valid_d = 1'b1;
          frame_d = frame_q + 1'b1;
          if (!EN) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      div_q     <= '0;
      warm_q    <= '0;
      frame_q   <= '0;
      bits_q    <= '0;
      valid_q   <= 1'b0;
      pdm_clk_q <= 1'b0;
      sync_q    <= '0;
      l_q       <= '0;
      r_q       <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      warm_q    <= warm_d;
      frame_q   <= frame_d;
      bits_q    <= bits_d;
      valid_q   <= valid_d;
      pdm_clk_q <= pdm_clk_d;
      sync_q    <= sync_d;
      l_q       <= l_d;
      r_q       <= r_d;
    end
  end

  assign pdm_clk_o    = pdm_clk_q;
  assign bits_o       = bits_q;
  assign bits_valid_o = valid_q;
  assign state_o      = state_q;
  assign frame_cnt_o  = frame_q;

endmodule
